// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall control slice.
// Contents: register address width, FSM state encoding and stall-need codes.
package pipe_ctrl_pkg;

   localparam int unsigned REG_AW = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_e;

   // Number of bubble cycles a hazard requires before operands are forwardable.
   localparam logic [1:0] NEED_NONE = 2'd0;
   localparam logic [1:0] NEED_1    = 2'd1;
   localparam logic [1:0] NEED_2    = 2'd2;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classification for the instruction in ID against the one in EX.
// Ports:
//   id_rsaddr_i, id_rtaddr_i  source registers of the ID instruction
//   id_uses_rt_i              ID instruction reads rt
//   id_branch_i               ID instruction is a branch resolved in ID
//   ex_writeaddr_i            destination register of the EX instruction
//   ex_regwrite_i             EX instruction writes a register
//   ex_memread_i              EX instruction is a load
//   lu_o                      load-use hazard
//   bl_o                      branch operand produced by a load in EX
//   ba_o                      branch operand produced by an ALU op in EX
//   need_o                    bubble cycles required (NEED_NONE/NEED_1/NEED_2)
module hazard_detect #(
   parameter int unsigned REG_AW = pipe_ctrl_pkg::REG_AW
) (
   input  logic [REG_AW-1:0] id_rsaddr_i,
   input  logic [REG_AW-1:0] id_rtaddr_i,
   input  logic              id_uses_rt_i,
   input  logic              id_branch_i,
   input  logic [REG_AW-1:0] ex_writeaddr_i,
   input  logic              ex_regwrite_i,
   input  logic              ex_memread_i,
   output logic              lu_o,
   output logic              bl_o,
   output logic              ba_o,
   output logic [1:0]        need_o
);
   import pipe_ctrl_pkg::*;

   logic ex_dst_valid;
   logic hit;

   // Register 0 is hard-wired, so a write to it never creates a dependency.
   assign ex_dst_valid = (ex_writeaddr_i != '0);
   assign hit = ex_dst_valid &
                ((ex_writeaddr_i == id_rsaddr_i) |
                 (id_uses_rt_i & (ex_writeaddr_i == id_rtaddr_i)));

   assign lu_o = ex_memread_i & hit;
   assign bl_o = id_branch_i & ex_memread_i & hit;
   assign ba_o = id_branch_i & ex_regwrite_i & ~ex_memread_i & hit;

   // A branch on a load result waits for MEM, so it takes precedence.
   always_comb begin
      need_o = NEED_NONE;
      if (bl_o) begin
         need_o = NEED_2;
      end else if (lu_o || ba_o) begin
         need_o = NEED_1;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard stall controller beside the ID stage of the 5-stage pipeline.
// Inserts bubbles for load-use and branch-in-ID operand hazards and freezes the
// back end of the pipeline while the dcache services a miss.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            leaves IDLE on the first high cycle
//   id_*               hazard info from the ID stage
//   ex_*               destination/control info from ID/EX
//   dcache_stall_i     dcache miss in progress
//   pc_write_o         PC load enable
//   ifid_write_o       IF/ID load enable
//   ifid_flush_o       IF/ID cleared to nop (taken branch)
//   idex_bubble_o      ID/EX control fields forced to 0
//   pipe_freeze_o      ID/EX, EX/MEM and MEM/WB hold
// Optional (macro HAZARD_PERF_EN):
//   stall_cycles_o     saturating count of bubble cycles
//   freeze_cycles_o    saturating count of freeze cycles
module hazard_stall_ctrl #(
   parameter int unsigned REG_AW    = pipe_ctrl_pkg::REG_AW,
   parameter int unsigned MAX_STALL = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [REG_AW-1:0] id_rsaddr_i,
   input  logic [REG_AW-1:0] id_rtaddr_i,
   input  logic              id_uses_rt_i,
   input  logic              id_branch_i,
   input  logic              id_branch_taken_i,
   input  logic [REG_AW-1:0] ex_writeaddr_i,
   input  logic              ex_regwrite_i,
   input  logic              ex_memread_i,
   input  logic              dcache_stall_i,
   output logic              pc_write_o,
   output logic              ifid_write_o,
   output logic              ifid_flush_o,
   output logic              idex_bubble_o,
   output logic              pipe_freeze_o
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       stall_cycles_o,
   output logic [31:0]       freeze_cycles_o
`endif
);
   import pipe_ctrl_pkg::*;

   localparam int unsigned CNT_W = $clog2(MAX_STALL + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       lu, bl, ba;
   logic [1:0] need;
   logic       hazard;

   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard_detect (
      .id_rsaddr_i    (id_rsaddr_i),
      .id_rtaddr_i    (id_rtaddr_i),
      .id_uses_rt_i   (id_uses_rt_i),
      .id_branch_i    (id_branch_i),
      .ex_writeaddr_i (ex_writeaddr_i),
      .ex_regwrite_i  (ex_regwrite_i),
      .ex_memread_i   (ex_memread_i),
      .lu_o           (lu),
      .bl_o           (bl),
      .ba_o           (ba),
      .need_o         (need)
   );

   assign hazard = lu | bl | ba;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_freeze_o = 1'b0;

      // Outputs stay quiet during reset so a reset cycle never advances the pipeline.
      if (!rst_i) begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_d = ST_RUN;
               end
            end

            ST_RUN: begin
               if (dcache_stall_i) begin
                  pipe_freeze_o = 1'b1;
               end else if (hazard) begin
                  // Any pending flush is deferred until the branch operands are valid.
                  idex_bubble_o = 1'b1;
                  if (need == NEED_2) begin
                     cnt_d   = CNT_W'(MAX_STALL - 1);
                     state_d = ST_STALL;
                  end
               end else begin
                  pc_write_o   = 1'b1;
                  ifid_write_o = 1'b1;
                  ifid_flush_o = id_branch_i & id_branch_taken_i;
               end
            end

            ST_STALL: begin
               // The stall decision was registered on entry; ID/EX inputs are not re-examined.
               if (dcache_stall_i) begin
                  pipe_freeze_o = 1'b1;
               end else begin
                  idex_bubble_o = 1'b1;
                  cnt_d         = cnt_q - CNT_W'(1);
                  if (cnt_q <= CNT_W'(1)) begin
                     state_d = ST_RUN;
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] freeze_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q  <= '0;
         freeze_cnt_q <= '0;
      end else begin
         if (idex_bubble_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (pipe_freeze_o && (freeze_cnt_q != 32'hFFFF_FFFF)) begin
            freeze_cnt_q <= freeze_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cycles_o  = stall_cnt_q;
   assign freeze_cycles_o = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: each driven cycle pushes its hand-computed
// expected outputs; a negedge monitor pops and compares against the DUT.
// Build with HAZARD_PERF_EN defined to also check the cycle counters.
module tb_hazard_stall_ctrl;

   // Expected output packing: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
   localparam logic [4:0] O_IDLE  = 5'b00000;
   localparam logic [4:0] O_RUN   = 5'b11000;
   localparam logic [4:0] O_FLUSH = 5'b11100;
   localparam logic [4:0] O_BUB   = 5'b00010;
   localparam logic [4:0] O_FRZ   = 5'b00001;

   typedef struct {
      string       name;
      logic [4:0]  outs;
      logic        chk_cnt;
      logic [31:0] stall_cnt;
      logic [31:0] freeze_cnt;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic       id_branch;
   logic       id_taken;
   logic [4:0] ex_waddr;
   logic       ex_regwrite;
   logic       ex_memread;
   logic       dcache_stall;
   logic       pc_write;
   logic       ifid_write;
   logic       ifid_flush;
   logic       idex_bubble;
   logic       pipe_freeze;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] freeze_cycles;
`endif

   exp_t        sb[$];
   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] run_stall  = 32'd0;
   logic [31:0] run_freeze = 32'd0;

   hazard_stall_ctrl #(
      .REG_AW    (5),
      .MAX_STALL (2)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .start_i           (start),
      .id_rsaddr_i       (id_rs),
      .id_rtaddr_i       (id_rt),
      .id_uses_rt_i      (id_uses_rt),
      .id_branch_i       (id_branch),
      .id_branch_taken_i (id_taken),
      .ex_writeaddr_i    (ex_waddr),
      .ex_regwrite_i     (ex_regwrite),
      .ex_memread_i      (ex_memread),
      .dcache_stall_i    (dcache_stall),
      .pc_write_o        (pc_write),
      .ifid_write_o      (ifid_write),
      .ifid_flush_o      (ifid_flush),
      .idex_bubble_o     (idex_bubble),
      .pipe_freeze_o     (pipe_freeze)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cycles_o    (stall_cycles),
      .freeze_cycles_o   (freeze_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the rising edge and queue what must be seen.
   task automatic step(input string name, input logic r, input logic s,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic tk, input logic [4:0] exw,
                       input logic exrw, input logic exmr, input logic dc,
                       input logic [4:0] outs);
      exp_t e;
      @(posedge clk);
      #1;
      rst          = r;
      start        = s;
      id_rs        = rs;
      id_rt        = rt;
      id_uses_rt   = urt;
      id_branch    = br;
      id_taken     = tk;
      ex_waddr     = exw;
      ex_regwrite  = exrw;
      ex_memread   = exmr;
      dcache_stall = dc;
      e.name       = name;
      e.outs       = outs;
      e.chk_cnt    = ~r;
      e.stall_cnt  = run_stall;
      e.freeze_cnt = run_freeze;
      sb.push_back(e);
      if (r) begin
         run_stall  = 32'd0;
         run_freeze = 32'd0;
      end else begin
         run_stall  = run_stall + {31'd0, outs[1]};
         run_freeze = run_freeze + {31'd0, outs[0]};
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t        e;
         logic [4:0]  act;
         e   = sb.pop_front();
         act = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze};
         n_total++;
         if (act === e.outs) n_pass++;
         else $display("FAIL %s: outputs got %b want %b", e.name, act, e.outs);
`ifdef HAZARD_PERF_EN
         if (e.chk_cnt) begin
            n_total++;
            if (stall_cycles === e.stall_cnt && freeze_cycles === e.freeze_cnt) n_pass++;
            else $display("FAIL %s_cnt: stall/freeze got %0d/%0d want %0d/%0d", e.name,
                          stall_cycles, freeze_cycles, e.stall_cnt, e.freeze_cnt);
         end
`endif
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
      id_branch = 1'b0; id_taken = 1'b0; ex_waddr = '0; ex_regwrite = 1'b0;
      ex_memread = 1'b0; dcache_stall = 1'b0;

      //    name            rst st  rs rt urt br tk exw rw mr dc expected
      step("rst0",          1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, O_IDLE);
      step("rst_start",     1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, O_IDLE);
      step("idle_start",    0, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, O_IDLE);
      step("run",           0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, O_RUN);
      // Load-use on rs, then rt with and without rt being read.
      step("lu_rs",         0, 0,  2, 0, 0, 0, 0,  2, 1, 1, 0, O_BUB);
      step("lu_after",      0, 0,  2, 0, 0, 0, 0,  0, 0, 0, 0, O_RUN);
      step("lu_rt_unused",  0, 0,  0, 2, 0, 0, 0,  2, 1, 1, 0, O_RUN);
      step("lu_rt_used",    0, 0,  0, 2, 1, 0, 0,  2, 1, 1, 0, O_BUB);
      step("lu_rt_after",   0, 0,  0, 2, 1, 0, 0,  0, 0, 0, 0, O_RUN);
      // Branch on a load result: two bubbles regardless of EX changing, then flush.
      step("bl_1",          0, 0,  3, 0, 0, 1, 1,  3, 1, 1, 0, O_BUB);
      step("bl_2",          0, 0,  3, 0, 0, 1, 1,  0, 0, 0, 0, O_BUB);
      step("bl_flush",      0, 0,  3, 0, 0, 1, 1,  0, 0, 0, 0, O_FLUSH);
      // Branch on an ALU result: one bubble.
      step("ba_rt",         0, 0,  0, 4, 1, 1, 1,  4, 1, 0, 0, O_BUB);
      step("ba_flush",      0, 0,  0, 4, 1, 1, 1,  0, 0, 0, 0, O_FLUSH);
      // Register 0 never creates a hazard.
      step("r0_alu",        0, 0,  0, 0, 1, 1, 0,  0, 1, 0, 0, O_RUN);
      step("r0_load",       0, 0,  0, 0, 1, 1, 1,  0, 1, 1, 0, O_FLUSH);
      // dcache freeze arriving while one stall cycle remains.
      step("frz_bl",        0, 0,  5, 0, 0, 1, 1,  5, 1, 1, 0, O_BUB);
      for (int i = 0; i < 5; i++) begin
         step("frz_stall",  0, 0,  5, 0, 0, 1, 1,  5, 1, 1, 1, O_FRZ);
      end
      step("frz_rel",       0, 0,  5, 0, 0, 1, 1,  0, 0, 0, 0, O_BUB);
      step("frz_flush",     0, 0,  5, 0, 0, 1, 1,  0, 0, 0, 0, O_FLUSH);
      // Freeze in RUN masks a hazard; the hazard is seen once the freeze drops.
      step("frz_run",       0, 0,  7, 0, 0, 0, 0,  7, 1, 1, 1, O_FRZ);
      step("frz_run_rel",   0, 0,  7, 0, 0, 0, 0,  7, 1, 1, 0, O_BUB);
      step("frz_run_after", 0, 0,  7, 0, 0, 0, 0,  0, 0, 0, 0, O_RUN);
      // Reset in the middle of a stall.
      step("bl_pre_rst",    0, 0,  6, 0, 0, 1, 1,  6, 1, 1, 0, O_BUB);
      step("rst_stall",     1, 0,  6, 0, 0, 1, 1,  6, 1, 1, 0, O_IDLE);
      step("idle_dcache",   0, 0,  6, 0, 0, 1, 1,  6, 1, 1, 1, O_IDLE);
      step("idle_start2",   0, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, O_IDLE);
      step("run2",          0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, O_RUN);

      // Let the monitor drain the scoreboard, bounded.
      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_total++;
         $display("FAIL drain: %0d entries left want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
